// File: rtl/ejtag_pracc_queue.sv
// EJTAG processor-access mailbox: queues core debug-segment accesses
// and presents them to the probe one at a time via PrAcc/PRnW.
module ejtag_pracc_queue #(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int DEPTH          = 4,
    parameter int POSTED_WRITES  = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         CORE_CLOCK,
    input  logic                         RESET_D1_R,
    input  logic                         REQ_VALID,
    input  logic                         REQ_WRITE,
    input  logic [AW-1:0]                REQ_ADDR,
    input  logic [1:0]                   REQ_SIZE,
    input  logic [DW-1:0]                REQ_WDATA,
    output logic                         REQ_READY,
    output logic                         RSP_VALID,
    output logic [DW-1:0]                RSP_RDATA,
    output logic                         RSP_ERR,
    input  logic                         PRB_EN,
    output logic                         PRB_PRACC,
    output logic                         PRB_PRNW,
    output logic [AW-1:0]                PRB_ADDR,
    output logic [1:0]                   PRB_SIZE,
    output logic [DW-1:0]                PRB_WDATA,
    input  logic [DW-1:0]                PRB_RDATA,
    input  logic                         PRB_ACK,
    output logic [$clog2(DEPTH+1)-1:0]   QUEUE_COUNT,
    output logic                         WR_ERR
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam bit POSTED = (POSTED_WRITES != 0);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_GAP
    } state_t;

    logic          q_write [DEPTH];
    logic [AW-1:0] q_addr  [DEPTH];
    logic [1:0]    q_size  [DEPTH];
    logic [DW-1:0] q_wdata [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          blocked_q;
    logic [TW-1:0] timer_q;
    state_t        state_q;
    state_t        state_d;

    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          wr_err_q;

    logic          push;
    logic          pop;
    logic          pop_err;
    logic          head_vld;
    logic          head_write;
    logic          head_np;
    logic          req_np;

    assign head_vld   = (count_q != '0);
    assign head_write = q_write[rd_ptr];
    assign head_np    = ~head_write | ~POSTED;
    assign req_np     = ~REQ_WRITE | ~POSTED;

    // A pending non-posted access holds off all new requests.
    assign REQ_READY = (count_q != FULL) & ~blocked_q;
    assign push      = REQ_VALID & REQ_READY;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        pop_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (head_vld | push) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // Ack wins over an expiring timer in the same cycle.
                if (PRB_ACK) begin
                    pop     = 1'b1;
                    state_d = ST_GAP;
                end else if (~PRB_EN | (timer_q == TLAST)) begin
                    pop     = 1'b1;
                    pop_err = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = (head_vld | push) ? ST_PRESENT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CORE_CLOCK) begin
        if (push) begin
            q_write[wr_ptr] <= REQ_WRITE;
            q_addr[wr_ptr]  <= REQ_ADDR;
            q_size[wr_ptr]  <= REQ_SIZE;
            q_wdata[wr_ptr] <= REQ_WDATA;
        end
    end

    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            state_q     <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            blocked_q   <= 1'b0;
            timer_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push & ~pop) begin
                count_q <= count_q + 1'b1;
            end else if (~push & pop) begin
                count_q <= count_q - 1'b1;
            end

            if (push & req_np) begin
                blocked_q <= 1'b1;
            end else if (pop & head_np) begin
                blocked_q <= 1'b0;
            end

            // Restarts from zero whenever PRESENT is (re)entered.
            if ((state_q == ST_PRESENT) && (state_d == ST_PRESENT)) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end

            rsp_valid_q <= (push & REQ_WRITE & POSTED) | (pop & head_np);
            rsp_err_q   <= pop & head_np & pop_err;
            if (pop & head_np & ~pop_err & ~head_write) begin
                rsp_rdata_q <= PRB_RDATA;
            end else begin
                rsp_rdata_q <= '0;
            end

            if (pop & pop_err & ~head_np) begin
                wr_err_q <= 1'b1;
            end
        end
    end

    assign PRB_PRACC   = (state_q == ST_PRESENT);
    assign PRB_PRNW    = head_vld & head_write;
    assign PRB_ADDR    = head_vld ? q_addr[rd_ptr]  : '0;
    assign PRB_SIZE    = head_vld ? q_size[rd_ptr]  : '0;
    assign PRB_WDATA   = head_vld ? q_wdata[rd_ptr] : '0;

    assign RSP_VALID   = rsp_valid_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign QUEUE_COUNT = count_q;
    assign WR_ERR      = wr_err_q;

endmodule

// File: tb/tb_ejtag_pracc_queue.sv
// Bench for ejtag_pracc_queue: directed plan plus a randomized run
// scored against a transaction-level queue model.
module tb_ejtag_pracc_queue;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic [DW-1:0] req_wdata;
    logic          prb_en;
    logic [DW-1:0] prb_rdata;
    logic          prb_ack;

    logic          req_ready, rsp_valid, rsp_err, prb_pracc, prb_prnw, wr_err;
    logic [DW-1:0] rsp_rdata, prb_wdata;
    logic [AW-1:0] prb_addr;
    logic [1:0]    prb_size;
    logic [2:0]    queue_count;

    logic          n_req_ready, n_rsp_valid, n_rsp_err, n_prb_pracc, n_prb_prnw, n_wr_err;
    logic [DW-1:0] n_rsp_rdata, n_prb_wdata;
    logic [AW-1:0] n_prb_addr;
    logic [1:0]    n_prb_size;
    logic [2:0]    n_queue_count;

    ejtag_pracc_queue #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH),
        .POSTED_WRITES(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CORE_CLOCK(clk), .RESET_D1_R(rst),
        .REQ_VALID(req_valid), .REQ_WRITE(req_write),
        .REQ_ADDR(req_addr), .REQ_SIZE(req_size),
        .REQ_WDATA(req_wdata), .REQ_READY(req_ready),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
        .RSP_ERR(rsp_err), .PRB_EN(prb_en),
        .PRB_PRACC(prb_pracc), .PRB_PRNW(prb_prnw),
        .PRB_ADDR(prb_addr), .PRB_SIZE(prb_size),
        .PRB_WDATA(prb_wdata), .PRB_RDATA(prb_rdata),
        .PRB_ACK(prb_ack), .QUEUE_COUNT(queue_count),
        .WR_ERR(wr_err)
    );

    ejtag_pracc_queue #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH),
        .POSTED_WRITES(0), .TIMEOUT_CYCLES(TO)
    ) dut_np (
        .CORE_CLOCK(clk), .RESET_D1_R(rst),
        .REQ_VALID(req_valid), .REQ_WRITE(req_write),
        .REQ_ADDR(req_addr), .REQ_SIZE(req_size),
        .REQ_WDATA(req_wdata), .REQ_READY(n_req_ready),
        .RSP_VALID(n_rsp_valid), .RSP_RDATA(n_rsp_rdata),
        .RSP_ERR(n_rsp_err), .PRB_EN(prb_en),
        .PRB_PRACC(n_prb_pracc), .PRB_PRNW(n_prb_prnw),
        .PRB_ADDR(n_prb_addr), .PRB_SIZE(n_prb_size),
        .PRB_WDATA(n_prb_wdata), .PRB_RDATA(prb_rdata),
        .PRB_ACK(prb_ack), .QUEUE_COUNT(n_queue_count),
        .WR_ERR(n_wr_err)
    );

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [1:0]    s;
        logic [DW-1:0] d;
    } ent_t;

    int   checks = 0;
    int   failures = 0;
    ent_t mq[$];
    ent_t h;
    ent_t nr;
    bit   np_pend, gap, e_rv, e_re, e_wr, rdy_exp;
    logic [DW-1:0] e_rd;
    int   age, hi, dbl;
    bit   prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        prb_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk("ready_before_push", req_ready, 1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = 2'b10;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ack_now();
        prb_ack = 1'b1;
        tick();
        prb_ack = 1'b0;
    endtask

    initial begin
        req_write = 0; req_addr = 0; req_size = 0; req_wdata = 0;
        prb_en = 1'b1;
        prb_rdata = '0;
        do_reset();

        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_pracc", prb_pracc, 0);
        chk("rst_prnw", prb_prnw, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_wr_err", wr_err, 0);

        // four posted writes fill the queue
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 32'hFF20_0000 + 32'(4*i), 32'h11 * 32'(i+1));
            chk("pw_rsp", rsp_valid, 1);
            chk("pw_rsp_err", rsp_err, 0);
        end
        chk("pw_count_full", queue_count, 4);
        chk("pw_ready_full", req_ready, 0);
        chk("pw_pracc", prb_pracc, 1);
        for (int i = 0; i < 4; i++) begin
            chk("pw_addr", prb_addr, 32'hFF20_0000 + 32'(4*i));
            chk("pw_wdata", prb_wdata, 32'h11 * 32'(i+1));
            chk("pw_prnw", prb_prnw, 1);
            ack_now();
            chk("pw_gap", prb_pracc, 0);
            chk("pw_no_rsp", rsp_valid, 0);
            chk("pw_count", queue_count, 64'(3-i));
            if (i == 0) begin
                ack_now();
                chk("stray_ack_count", queue_count, 3);
            end else begin
                tick();
            end
            chk("pw_next", prb_pracc, 64'(i < 3));
        end

        // read queued behind two writes
        push_req(1'b1, 32'hFF20_0100, 32'h1);
        push_req(1'b1, 32'hFF20_0104, 32'h2);
        push_req(1'b0, 32'hFF20_0200, 32'h0);
        chk("rd_blocked", req_ready, 0);
        ack_now();
        chk("rd_blocked_gap1", req_ready, 0);
        tick();
        chk("rd_w1_pracc", prb_pracc, 1);
        ack_now();
        chk("rd_blocked_gap2", req_ready, 0);
        tick();
        chk("rd_third_pracc", prb_pracc, 1);
        chk("rd_third_prnw", prb_prnw, 0);
        chk("rd_third_addr", prb_addr, 32'hFF20_0200);
        chk("rd_blocked_pres", req_ready, 0);
        prb_rdata = 32'hDEAD_BEEF;
        ack_now();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err", rsp_err, 0);
        chk("rd_ready_back", req_ready, 1);
        prb_rdata = '0;
        tick();

        // read timeout
        prb_rdata = 32'hA5A5_A5A5;
        push_req(1'b0, 32'hFF20_0300, 32'h0);
        hi = 0;
        while (prb_pracc && hi < 20) begin
            hi++;
            tick();
        end
        chk("to_rd_len", hi, TO);
        chk("to_rd_valid", rsp_valid, 1);
        chk("to_rd_err", rsp_err, 1);
        chk("to_rd_rdata", rsp_rdata, 0);
        tick();

        // posted write timeout
        chk("to_wr_err_before", wr_err, 0);
        push_req(1'b1, 32'hFF20_0304, 32'h77);
        chk("to_wr_posted_rsp", rsp_valid, 1);
        hi = 0;
        while (prb_pracc && hi < 20) begin
            hi++;
            tick();
        end
        chk("to_wr_len", hi, TO);
        chk("to_wr_no_rsp", rsp_valid, 0);
        chk("to_wr_err", wr_err, 1);
        tick();

        // ack landing on the expiry cycle
        push_req(1'b0, 32'hFF20_0308, 32'h0);
        hi = 1;
        while (hi < TO) begin
            tick();
            hi++;
        end
        chk("exp_pracc", prb_pracc, 1);
        prb_rdata = 32'h5;
        ack_now();
        chk("exp_valid", rsp_valid, 1);
        chk("exp_err", rsp_err, 0);
        chk("exp_rdata", rsp_rdata, 32'h5);
        tick();

        // probe disabled: each entry errors after one PrAcc cycle
        do_reset();
        chk("dis_wr_err_clr", wr_err, 0);
        prb_en = 1'b0;
        hi = 0;
        dbl = 0;
        prev = 1'b0;
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 3);
            req_write = 1'b1;
            req_addr  = 32'hFF20_0400 + 32'(4*k);
            req_wdata = 32'(k);
            tick();
            if (prb_pracc) hi++;
            if (prb_pracc && prev) dbl++;
            prev = prb_pracc;
        end
        req_valid = 1'b0;
        chk("dis_present_cnt", hi, 3);
        chk("dis_single_cycle", dbl, 0);
        chk("dis_drained", queue_count, 0);
        chk("dis_wr_err", wr_err, 1);
        prb_en = 1'b1;
        tick();

        // reset while busy, colliding with a request and an ack
        for (int i = 0; i < 3; i++) begin
            push_req(1'b1, 32'hFF20_0500 + 32'(4*i), 32'(i));
        end
        chk("mid_count", queue_count, 3);
        chk("mid_pracc", prb_pracc, 1);
        rst = 1'b1;
        req_valid = 1'b1;
        prb_ack = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 1'b0;
        prb_ack = 1'b0;
        chk("mid_rst_count", queue_count, 0);
        chk("mid_rst_pracc", prb_pracc, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_wr_err", wr_err, 0);
        tick();
        chk("mid_rst_count2", queue_count, 0);
        chk("mid_rst_rsp2", rsp_valid, 0);

        // non-posted write blocks until acknowledged
        do_reset();
        chk("np_ready_rst", n_req_ready, 1);
        push_req(1'b1, 32'hFF20_0600, 32'h99);
        chk("np_ready_low", n_req_ready, 0);
        chk("np_no_rsp", n_rsp_valid, 0);
        chk("np_pracc", n_prb_pracc, 1);
        tick();
        tick();
        chk("np_ready_still_low", n_req_ready, 0);
        chk("np_no_rsp2", n_rsp_valid, 0);
        ack_now();
        chk("np_rsp_valid", n_rsp_valid, 1);
        chk("np_rsp_err", n_rsp_err, 0);
        chk("np_rsp_rdata", n_rsp_rdata, 0);
        chk("np_ready_back", n_req_ready, 1);
        tick();

        // randomized traffic against the queue model
        do_reset();
        mq.delete();
        np_pend = 0; gap = 0; e_rv = 0; e_re = 0; e_wr = 0;
        e_rd = '0; age = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rdy_exp = (mq.size() < DEPTH) && !np_pend;
            chk("m_rsp_valid", rsp_valid, 64'(e_rv));
            chk("m_rsp_err", rsp_err, 64'(e_re));
            chk("m_rsp_rdata", rsp_rdata, e_rd);
            chk("m_count", queue_count, 64'(mq.size()));
            chk("m_ready", req_ready, 64'(rdy_exp));
            chk("m_pracc", prb_pracc, 64'(mq.size() > 0 && !gap));
            chk("m_wr_err", wr_err, 64'(e_wr));

            e_rv = 0; e_re = 0; e_rd = '0; gap = 0;
            prb_ack = 1'b0;
            prb_rdata = $urandom;
            if (prb_pracc && mq.size() > 0) begin
                chk("m_prnw", prb_prnw, 64'(mq[0].w));
                chk("m_addr", prb_addr, mq[0].a);
                chk("m_size", prb_size, 64'(mq[0].s));
                chk("m_wdata", prb_wdata, mq[0].d);
                age++;
                prb_ack = ($urandom_range(3) == 0);
                if (prb_ack || age == TO) begin
                    h = mq.pop_front();
                    if (!h.w) begin
                        e_rv = 1;
                        e_re = !prb_ack;
                        e_rd = prb_ack ? prb_rdata : '0;
                        np_pend = 0;
                    end else if (!prb_ack) begin
                        e_wr = 1;
                    end
                    gap = 1;
                    age = 0;
                end
            end

            req_valid = ($urandom_range(1) == 1);
            req_write = ($urandom_range(2) != 0);
            req_addr  = $urandom;
            req_size  = 2'($urandom_range(2));
            req_wdata = $urandom;
            if (req_valid && rdy_exp) begin
                nr.w = req_write;
                nr.a = req_addr;
                nr.s = req_size;
                nr.d = req_wdata;
                mq.push_back(nr);
                if (req_write) begin
                    e_rv = 1;
                    e_re = 0;
                    e_rd = '0;
                end else begin
                    np_pend = 1;
                end
            end
            tick();
        end
        req_valid = 1'b0;
        prb_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
